instr_prefetch_queue: RTL and testbench

Fetch front-end that sits directly upstream of the single-cycle core's instruction input. It generates sequential fetch addresses, issues them to instruction memory over a valid/ready request channel, and buffers in-order responses in a DEPTH-entry FIFO. It presents each instruction with its PC to the core over a valid/ready channel. A core redirect (taken branch, JAL or JALR) flushes the queue and discards any responses already in flight.

---
 rtl/instr_prefetch_queue.sv | 117 +++++++++++
 tb/tb_instr_prefetch_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: issues word fetches, queues in-order responses with their PCs, flushes on redirect.
// Latency: request accepted at N, response at N+k, instr_valid at N+k+1 (N+k with IFQ_BYPASS_EN defined).
// Backpressure: credits stop requests once queued + outstanding reach DEPTH; mem_req_addr holds while mem_req_ready=0.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] count, inflight, drop_cnt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   fpc, rsp_pc, last_instr, last_pc, redirect_base;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [CW:0]   occupancy;
    logic          req_fire, rsp_ok, rsp_drop, rsp_take, byp, byp_take, push, pop;

    always_comb begin
        occupancy     = {1'b0, count} + {1'b0, inflight};
        redirect_base = redirect_pc & ~32'h3;
        // Outputs are forced quiet while reset is asserted, not just after the next edge.
        mem_req_valid = rst && !redirect && (occupancy < (CW+1)'(DEPTH));
        mem_req_addr  = fpc;
        req_fire      = mem_req_valid && mem_req_ready;
        rsp_ok        = mem_rsp_valid && (inflight != '0);
        rsp_drop      = rsp_ok && (drop_cnt != '0);
        rsp_take      = rsp_ok && !rsp_drop && !redirect;
`ifdef IFQ_BYPASS_EN
        byp           = rsp_take && (count == '0);
`else
        byp           = 1'b0;
`endif
        byp_take      = byp && instr_ready;
        push          = rsp_take && !byp_take;
        pop           = (count != '0) && instr_ready && !redirect;
        instr_valid   = rst && ((count != '0) || byp);
        if (count != '0) begin
            instr    = q_instr[rd_ptr];
            instr_pc = q_pc[rd_ptr];
        end else if (byp) begin
            instr    = mem_rsp_data;
            instr_pc = rsp_pc;
        end else begin
            instr    = last_instr;
            instr_pc = last_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc        <= RESET_PC;
            rsp_pc     <= RESET_PC;
            count      <= '0;
            inflight   <= '0;
            drop_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_instr <= '0;
            last_pc    <= '0;
        end else if (redirect) begin
            // Everything still outstanding belongs to the old path and must be swallowed.
            fpc      <= redirect_base;
            rsp_pc   <= redirect_base;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= inflight - CW'(rsp_ok);
            drop_cnt <= inflight - CW'(rsp_ok);
        end else begin
            if (req_fire) fpc <= fpc + 32'd4;
            if (rsp_take) rsp_pc <= rsp_pc + 32'd4;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
            count    <= count + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(req_fire) - CW'(rsp_ok);
            if (pop) begin
                last_instr <= q_instr[rd_ptr];
                last_pc    <= q_pc[rd_ptr];
            end else if (byp_take) begin
                last_instr <= mem_rsp_data;
                last_pc    <= rsp_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= mem_rsp_data;
            q_pc[wr_ptr]    <= rsp_pc;
        end
    end

    rsp_needs_request: assert property (@(posedge clk) disable iff (!rst)
        mem_rsp_valid |-> (inflight != '0));
    credit_bound: assert property (@(posedge clk) disable iff (!rst)
        occupancy <= (CW+1)'(DEPTH));
    drop_bound: assert property (@(posedge clk) disable iff (!rst)
        drop_cnt <= inflight);

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with an in-order, fixed-latency memory model.
module tb_instr_prefetch_queue;

`ifdef IFQ_BYPASS_EN
    localparam int LAT1 = 1;
`else
    localparam int LAT1 = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory model: each accepted request answers mem_lat cycles later, in order.
    int          cyc = 0;
    int          mem_lat = 1;
    logic        rsp_v = 1'b0;
    logic [31:0] rsp_d = '0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    assign mem_rsp_valid = rsp_v && rst;
    assign mem_rsp_data  = rsp_d;

    always @(negedge clk) begin
        if (!rst) begin
            q_addr.delete();
            q_due.delete();
        end else if (mem_req_valid && mem_req_ready) begin
            q_addr.push_back(mem_req_addr);
            q_due.push_back(cyc + mem_lat);
        end
    end

    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        rsp_v = 1'b0;
        if (rst && q_due.size() > 0 && q_due[0] <= cyc) begin
            rsp_v = 1'b1;
            rsp_d = mdata(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b0;
        redirect = 1'b0;
        mem_req_ready = 1'b0;
        instr_ready = 1'b0;
        mem_lat = lat;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        total++; if (mem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_req_addr: got %h want 0", mem_req_addr); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        do_reset(1);
        mem_req_ready = 1'b1;
        instr_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++; if (mem_req_addr !== 32'(4 * c)) begin bad++; $display("FAIL stream_addr c%0d: got %h want %h", c, mem_req_addr, 32'(4 * c)); end
            total++; if (instr_valid !== (c >= LAT1)) begin bad++; $display("FAIL stream_valid c%0d: got %b want %b", c, instr_valid, c >= LAT1); end
            if (c >= LAT1) begin
                exp_pc = 32'(4 * (c - LAT1));
                total++; if (instr_pc !== exp_pc || instr !== mdata(exp_pc)) begin
                    bad++; $display("FAIL stream_instr c%0d: got pc %h data %h want pc %h data %h", c, instr_pc, instr, exp_pc, mdata(exp_pc));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_full;
        int n = 0;
        do_reset(1);
        mem_req_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                total++; if (mem_req_addr !== 32'(4 * n)) begin bad++; $display("FAIL full_addr: got %h want %h", mem_req_addr, 32'(4 * n)); end
                n++;
            end
            if (c >= 4) begin
                total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL full_credit c%0d: got %b want 0", c, mem_req_valid); end
            end
            next_cycle();
        end
        total++; if (n !== 4) begin bad++; $display("FAIL full_req_count: got %0d want 4", n); end
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k)) begin
                bad++; $display("FAIL full_drain k%0d: got valid %b pc %h want 1 %h", k, instr_valid, instr_pc, 32'(4 * k));
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect_drop;
        int first = -1;
        logic [31:0] fpc_seen = 32'hFFFF_FFFF;
        logic [31:0] fdat_seen = 32'hFFFF_FFFF;
        do_reset(3);
        mem_req_ready = 1'b1;
        instr_ready = 1'b1;
        next_cycle();
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL drop_no_req: got %b want 0", mem_req_valid); end
        next_cycle();
        redirect = 1'b0;
        for (int c = 3; c < 13; c++) begin
            @(negedge clk);
            if (c == 3) begin
                total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
                    bad++; $display("FAIL drop_new_addr: got valid %b addr %h want 1 00000100", mem_req_valid, mem_req_addr);
                end
            end
            if (instr_valid && first < 0) begin
                first = c; fpc_seen = instr_pc; fdat_seen = instr;
            end
            next_cycle();
        end
        total++; if (first !== 5 + LAT1) begin bad++; $display("FAIL drop_first_cycle: got %0d want %0d", first, 5 + LAT1); end
        total++; if (fpc_seen !== 32'h100 || fdat_seen !== mdata(32'h100)) begin
            bad++; $display("FAIL drop_first_instr: got pc %h data %h want 00000100 %h", fpc_seen, fdat_seen, mdata(32'h100));
        end
    endtask

    task automatic test_redirect_same;
        int first = -1;
        logic [31:0] fpc_seen = 32'hFFFF_FFFF;
        logic [31:0] fdat_seen = 32'hFFFF_FFFF;
        do_reset(2);
        mem_req_ready = 1'b1;
        next_cycle();
        next_cycle();
        mem_req_ready = 1'b0;
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h203;
        instr_ready = 1'b1;
        @(negedge clk);
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || mem_rsp_valid !== 1'b1) begin
            bad++; $display("FAIL same_setup: got valid %b pc %h rsp %b want 1 00000000 1", instr_valid, instr_pc, mem_rsp_valid);
        end
        next_cycle();
        redirect = 1'b0;
        mem_req_ready = 1'b1;
        for (int c = 4; c < 13; c++) begin
            @(negedge clk);
            if (c == 4) begin
                total++; if (mem_req_addr !== 32'h200 || instr_valid !== 1'b0) begin
                    bad++; $display("FAIL same_after: got addr %h valid %b want 00000200 0", mem_req_addr, instr_valid);
                end
            end
            if (instr_valid && first < 0) begin
                first = c; fpc_seen = instr_pc; fdat_seen = instr;
            end
            next_cycle();
        end
        total++; if (first !== 5 + LAT1) begin bad++; $display("FAIL same_first_cycle: got %0d want %0d", first, 5 + LAT1); end
        total++; if (fpc_seen !== 32'h200 || fdat_seen !== mdata(32'h200)) begin
            bad++; $display("FAIL same_first_instr: got pc %h data %h want 00000200 %h", fpc_seen, fdat_seen, mdata(32'h200));
        end
    endtask

    task automatic test_req_stall;
        do_reset(1);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_redirect_req: got %b want 0", mem_req_valid); end
        next_cycle();
        redirect = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40 || instr_valid !== 1'b0) begin
                bad++; $display("FAIL stall_hold c%0d: got valid %b addr %h ivalid %b want 1 00000040 0", c, mem_req_valid, mem_req_addr, instr_valid);
            end
            next_cycle();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40) begin
            bad++; $display("FAIL stall_accept: got valid %b addr %h want 1 00000040", mem_req_valid, mem_req_addr);
        end
        next_cycle();
        mem_req_ready = 1'b0;
        @(negedge clk);
        total++; if (mem_req_addr !== 32'h44) begin bad++; $display("FAIL stall_advance: got %h want 00000044", mem_req_addr); end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        int first = -1;
        logic [31:0] fpc_seen = 32'hFFFF_FFFF;
        do_reset(1);
        mem_req_ready = 1'b1;
        repeat (4) next_cycle();
        #1;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL mid_setup: got %b want 1", instr_valid); end
        rst = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset_out: got ivalid %b rvalid %b want 0 0", instr_valid, mem_req_valid);
        end
        total++; if (instr_pc !== 32'h0 || mem_req_addr !== 32'h0) begin
            bad++; $display("FAIL mid_reset_pc: got pc %h addr %h want 0 0", instr_pc, mem_req_addr);
        end
        next_cycle();
        rst = 1'b1;
        instr_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
                    bad++; $display("FAIL mid_restart: got valid %b addr %h want 1 0", mem_req_valid, mem_req_addr);
                end
            end
            if (instr_valid && first < 0) begin
                first = c; fpc_seen = instr_pc;
            end
            next_cycle();
        end
        total++; if (first !== LAT1 || fpc_seen !== 32'h0) begin
            bad++; $display("FAIL mid_first: got cycle %0d pc %h want %0d 0", first, fpc_seen, LAT1);
        end
    endtask

    initial begin
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        mem_req_ready = 1'b0;
        instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_drop();
        test_redirect_same();
        test_req_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
